// File: rtl/freq_gen.sv
// Programmable square-wave burst generator: emits P rising edges (or runs continuously)
// with N clk cycles per high phase and per low phase.
module freq_gen #(
    parameter int CNT_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half_period,
    input  logic [CNT_W-1:0] cfg_pulses,
    input  logic             stop,
    output logic             signal_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_r;
    logic [CNT_W-1:0] half_r;
    logic [CNT_W-1:0] target_r;
    // Cycles already spent in the current phase, counting the entry cycle as 1.
    logic [CNT_W-1:0] phase_cnt_r;

    // Burst FSM with every output registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            half_r      <= CNT_ONE;
            target_r    <= CNT_ZERO;
            phase_cnt_r <= CNT_ZERO;
            signal_out  <= 1'b0;
            busy        <= 1'b0;
            cfg_ready   <= 1'b1;
            done        <= 1'b0;
            pulses_sent <= CNT_ZERO;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cfg_valid && !stop) begin
                        state_r     <= HIGH;
                        half_r      <= (cfg_half_period == CNT_ZERO) ? CNT_ONE : cfg_half_period;
                        target_r    <= cfg_pulses;
                        phase_cnt_r <= CNT_ONE;
                        signal_out  <= 1'b1;
                        busy        <= 1'b1;
                        cfg_ready   <= 1'b0;
                        pulses_sent <= CNT_ONE;
                    end else begin
                        signal_out <= 1'b0;
                        busy       <= 1'b0;
                        cfg_ready  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (stop) begin
                        state_r    <= IDLE;
                        signal_out <= 1'b0;
                        busy       <= 1'b0;
                        cfg_ready  <= 1'b1;
                    end else if (phase_cnt_r == half_r) begin
                        state_r     <= LOW;
                        phase_cnt_r <= CNT_ONE;
                        signal_out  <= 1'b0;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + CNT_ONE;
                    end
                end
                LOW: begin
                    if (stop) begin
                        state_r    <= IDLE;
                        signal_out <= 1'b0;
                        busy       <= 1'b0;
                        cfg_ready  <= 1'b1;
                    end else if (phase_cnt_r == half_r) begin
                        if ((target_r != CNT_ZERO) && (pulses_sent == target_r)) begin
                            state_r    <= IDLE;
                            signal_out <= 1'b0;
                            busy       <= 1'b0;
                            cfg_ready  <= 1'b1;
                            done       <= 1'b1;
                        end else begin
                            state_r     <= HIGH;
                            phase_cnt_r <= CNT_ONE;
                            signal_out  <= 1'b1;
                            // Continuous mode pins the count at all-ones rather than wrapping.
                            if (pulses_sent != CNT_MAX) begin
                                pulses_sent <= pulses_sent + CNT_ONE;
                            end else begin
                                pulses_sent <= pulses_sent;
                            end
                        end
                    end else begin
                        phase_cnt_r <= phase_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    signal_out <= 1'b0;
                    busy       <= 1'b0;
                    cfg_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gen.sv
// Directed bench for freq_gen: table of burst vectors plus hand-written stop, reset,
// stop-versus-config and saturation sequences.
module tb_freq_gen;

    localparam int W = 40;

    logic         clk;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_half_period;
    logic [W-1:0] cfg_pulses;
    logic         stop;
    logic         signal_out;
    logic         busy;
    logic         done;
    logic [W-1:0] pulses_sent;

    logic         s_cfg_valid;
    logic         s_cfg_ready;
    logic [2:0]   s_half;
    logic [2:0]   s_pulses;
    logic         s_stop;
    logic         s_signal;
    logic         s_busy;
    logic         s_done;
    logic [2:0]   s_sent;

    int checks   = 0;
    int failures = 0;

    freq_gen #(.CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_half_period(cfg_half_period), .cfg_pulses(cfg_pulses), .stop(stop),
        .signal_out(signal_out), .busy(busy), .done(done), .pulses_sent(pulses_sent)
    );

    freq_gen #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready),
        .cfg_half_period(s_half), .cfg_pulses(s_pulses), .stop(s_stop),
        .signal_out(s_signal), .busy(s_busy), .done(s_done), .pulses_sent(s_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] n;
        logic [W-1:0] p;
        logic [15:0]  wave;
        int           len;
        int           done_edge;
        logic [W-1:0] final_pulses;
        bit           poke;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a configuration for one edge; returns #1 after the acceptance edge.
    task automatic accept(input logic [W-1:0] n, input logic [W-1:0] p);
        cfg_valid       = 1'b1;
        cfg_half_period = n;
        cfg_pulses      = p;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_half_period = '0; cfg_pulses = '0; stop = 1'b0;
        s_cfg_valid = 1'b0; s_half = 3'd0; s_pulses = 3'd0; s_stop = 1'b0;

        vecs[0] = '{n: 40'd3, p: 40'd2, wave: 16'h01C7, len: 13, done_edge: 12, final_pulses: 40'd2, poke: 1'b0};
        vecs[1] = '{n: 40'd0, p: 40'd4, wave: 16'h0055, len: 9,  done_edge: 8,  final_pulses: 40'd4, poke: 1'b0};
        vecs[2] = '{n: 40'd2, p: 40'd1, wave: 16'h0003, len: 5,  done_edge: 4,  final_pulses: 40'd1, poke: 1'b0};
        vecs[3] = '{n: 40'd1, p: 40'd3, wave: 16'h0015, len: 7,  done_edge: 6,  final_pulses: 40'd3, poke: 1'b0};
        vecs[4] = '{n: 40'd2, p: 40'd2, wave: 16'h0033, len: 9,  done_edge: 8,  final_pulses: 40'd2, poke: 1'b1};

        repeat (3) tick();
        check("rst_signal_out", 64'(signal_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pulses_sent", 64'(pulses_sent), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            accept(vecs[v].n, vecs[v].p);
            for (int k = 0; k < vecs[v].len; k++) begin
                if (k > 0) tick();
                check($sformatf("v%0d_e%0d_signal_out", v, k), 64'(signal_out), 64'(vecs[v].wave[k]));
                check($sformatf("v%0d_e%0d_done", v, k), 64'(done), 64'(k == vecs[v].done_edge));
                check($sformatf("v%0d_e%0d_busy", v, k), 64'(busy), 64'(k < vecs[v].done_edge));
                check($sformatf("v%0d_e%0d_cfg_ready", v, k), 64'(cfg_ready), 64'(k >= vecs[v].done_edge));
                if (vecs[v].poke && k == 1) begin
                    cfg_valid = 1'b1; cfg_half_period = 40'd5; cfg_pulses = 40'd7;
                end else if (vecs[v].poke && k == 3) begin
                    cfg_valid = 1'b0;
                end
            end
            check($sformatf("v%0d_pulses_sent", v), 64'(pulses_sent), 64'(vecs[v].final_pulses));
            repeat (2) tick();
            check($sformatf("v%0d_pulses_hold", v), 64'(pulses_sent), 64'(vecs[v].final_pulses));
            check($sformatf("v%0d_idle_done", v), 64'(done), 64'd0);
        end

        // Continuous N=2: 5th rising edge lands on edge 16, stop raised right after it.
        accept(40'd2, 40'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("cont_e%0d_done", k), 64'(done), 64'd0);
        end
        check("cont_pulses_5", 64'(pulses_sent), 64'd5);
        check("cont_signal_high", 64'(signal_out), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_signal_out", 64'(signal_out), 64'd0);
        check("stop_pulses_sent", 64'(pulses_sent), 64'd5);
        check("stop_done", 64'(done), 64'd0);
        check("stop_busy", 64'(busy), 64'd0);
        check("stop_cfg_ready", 64'(cfg_ready), 64'd1);

        // Stop and cfg_valid together in IDLE: nothing accepted.
        cfg_valid = 1'b1; stop = 1'b1; cfg_half_period = 40'd3; cfg_pulses = 40'd1;
        tick();
        cfg_valid = 1'b0; stop = 1'b0;
        check("idle_stop_busy", 64'(busy), 64'd0);
        check("idle_stop_cfg_ready", 64'(cfg_ready), 64'd1);
        check("idle_stop_signal", 64'(signal_out), 64'd0);
        check("idle_stop_pulses", 64'(pulses_sent), 64'd5);
        tick();
        check("idle_stop_busy_later", 64'(busy), 64'd0);

        // Saturation on a 3-bit instance: N=1 continuous passes 7 rising edges by edge 12.
        s_cfg_valid = 1'b1; s_half = 3'd1; s_pulses = 3'd0;
        tick();
        s_cfg_valid = 1'b0;
        for (int k = 1; k <= 20; k++) tick();
        check("sat_pulses", 64'(s_sent), 64'd7);
        check("sat_signal_high", 64'(s_signal), 64'd1);
        check("sat_busy", 64'(s_busy), 64'd1);
        tick();
        check("sat_signal_low", 64'(s_signal), 64'd0);
        s_stop = 1'b1;
        tick();
        s_stop = 1'b0;
        check("sat_stop_busy", 64'(s_busy), 64'd0);

        // Reset in the middle of an N=10 high phase.
        accept(40'd10, 40'd0);
        repeat (3) tick();
        check("midrst_pre_signal", 64'(signal_out), 64'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_signal_out", 64'(signal_out), 64'd0);
        check("midrst_pulses_sent", 64'(pulses_sent), 64'd0);
        check("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();
        check("midrst_after_done", 64'(done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_gen.md
FREQ_GEN -- requirements
Module: freq_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 40, giving the width of the half-period, pulse-count and pulse-counter fields.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cfg_valid  input  1  configuration request.
REQ-005 SHALL have port cfg_ready  output  1  block accepts configuration; high only in IDLE.
REQ-006 SHALL have port cfg_half_period  input  CNT_W  clk cycles per high phase and per low phase; 0 treated as 1.
REQ-007 SHALL have port cfg_pulses  input  CNT_W  rising edges to emit; 0 means continuous.
REQ-008 SHALL have port stop  input  1  abort request.
REQ-009 SHALL have port signal_out  output  1  generated square wave; feeds a frequency-measurement input.
REQ-010 SHALL have port busy  output  1  high in HIGH or LOW state.
REQ-011 SHALL have port done  output  1  one-cycle pulse on normal burst completion.
REQ-012 SHALL have port pulses_sent  output  CNT_W  rising edges emitted in the current or last burst.

Function
REQ-013 SHALL implement states IDLE, HIGH, LOW; all outputs registered.
REQ-014 SHALL accept configuration on the edge where cfg_valid and cfg_ready are both high and stop is low; cfg_valid at any other time is ignored.
REQ-015 SHALL, on the acceptance edge, latch half-period N (0 -> 1) and pulse target P, enter HIGH, set signal_out=1, and set pulses_sent=1.
REQ-016 SHALL hold signal_out high for exactly N clk cycles, then low for exactly N clk cycles, giving period 2N cycles and f_out = f_clk/(2N).
REQ-017 SHALL, at the end of a LOW phase with P!=0 and pulses_sent==P, enter IDLE, keep signal_out=0, and pulse done for one cycle.
REQ-018 SHALL otherwise, at the end of a LOW phase, enter HIGH, set signal_out=1, and increment pulses_sent.
REQ-019 SHALL saturate pulses_sent at 2^CNT_W-1 in continuous mode and keep toggling.
REQ-020 SHALL, when stop is high in HIGH or LOW, enter IDLE on that edge with signal_out=0 and done=0, holding pulses_sent.
REQ-021 SHALL give stop priority over cfg_valid in the same cycle: no acceptance.
REQ-022 SHALL hold pulses_sent after completion until the next acceptance.
REQ-023 SHALL never let signal_out glitch: exactly one transition per phase boundary.
REQ-024 SHALL set busy = (state != IDLE) and cfg_ready = (state == IDLE).

Reset
REQ-025 SHALL, when rst_n is low at a rising clk edge, force state IDLE, signal_out=0, done=0, busy=0, cfg_ready=1, pulses_sent=0, and clear internal counters.
REQ-026 SHALL let reset override every other input, including mid-burst; no done pulse results.

Verification
REQ-027 SHALL verify N=3, P=2: signal_out reads 1,1,1,0,0,0,1,1,1,0,0,0 starting at the acceptance edge; done is high one cycle at edge 12; pulses_sent=2; cfg_ready returns to 1.
REQ-028 SHALL verify N=0, P=4: signal_out toggles every cycle (treated as N=1); 4 rising edges; done at edge 8.
REQ-029 SHALL verify P=0, N=2 with stop asserted after the 5th rising edge: signal_out=0 the next cycle; pulses_sent=5; done never asserts.
REQ-030 SHALL verify cfg_valid pulsed mid-burst with different values: ignored, and the burst completes with the original N and P.
REQ-031 SHALL verify rst_n low mid-HIGH during an N=10 burst: next cycle signal_out=0, pulses_sent=0, cfg_ready=1, done=0.
REQ-032 SHALL verify cfg_valid and stop high together in IDLE: no acceptance and busy stays 0.
